// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, engine state encoding and control width shared by
// alu_muldiv and its iterative multiply/divide engine.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_MULT  = 4'b1000,
        ALU_MULTU = 4'b1001,
        ALU_DIV   = 4'b1010,
        ALU_DIVU  = 4'b1011,
        ALU_NOR   = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ITER,
        FIX
    } muldiv_state_e;

    // Codes 10xx select the multi-cycle engine; bit 1 picks divide, bit 0 unsigned.
    function automatic logic is_muldiv(input logic [ALU_CTRL_W-1:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative shift-add multiplier / restoring divider working on
// operand magnitudes, one step per clock, with a final sign fix-up into HI/LO.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    import alu_pkg::*;

    localparam int            CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    muldiv_state_e   state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            is_div_q, is_div_d;
    logic            a_neg_q, a_neg_d;
    logic            res_neg_q, res_neg_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic            done_q, done_d;
    logic            dbz_q, dbz_d;

    logic [WIDTH-1:0]   a_mag, b_mag, mul_addend;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // rem_q holds the running upper product half (mul) or partial remainder (div);
    // quo_q holds the shifting multiplier (mul) or dividend turning into quotient (div).
    always_comb begin
        a_mag      = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
        b_mag      = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
        mul_addend = quo_q[0] ? b_q : '0;
        mul_sum    = {1'b0, rem_q} + {1'b0, mul_addend};
        div_shift  = {rem_q, quo_q[WIDTH-1]};
        div_diff   = div_shift - {1'b0, b_q};

        if (is_div_q) begin
            if (div_diff[WIDTH]) begin
                step_rem = div_shift[WIDTH-1:0];
                step_quo = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                step_rem = div_diff[WIDTH-1:0];
                step_quo = {quo_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            step_rem = mul_sum[WIDTH:1];
            step_quo = {mul_sum[0], quo_q[WIDTH-1:1]};
        end

        prod     = {rem_q, quo_q};
        prod_fix = res_neg_q ? -prod : prod;
        quo_fix  = res_neg_q ? -quo_q : quo_q;
        rem_fix  = a_neg_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        is_div_d  = is_div_q;
        a_neg_d   = a_neg_q;
        res_neg_d = res_neg_q;
        b_d       = b_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = SETUP;
                    count_d   = COUNT_INIT;
                    is_div_d  = is_div_i;
                    a_neg_d   = is_signed_i && a_i[WIDTH-1];
                    res_neg_d = is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                    b_d       = b_mag;
                    rem_d     = '0;
                    quo_d     = a_mag;
                end
            end
            SETUP: begin
                if (is_div_q && (b_q == '0)) begin
                    state_d = IDLE;
                    count_d = '0;
                    done_d  = 1'b1;
                    dbz_d   = 1'b1;
                end else begin
                    state_d = ITER;
                    count_d = count_q - COUNT_ONE;
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                end
            end
            ITER: begin
                count_d = count_q - COUNT_ONE;
                rem_d   = step_rem;
                quo_d   = step_quo;
                if (count_q == COUNT_ONE) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            is_div_q  <= 1'b0;
            a_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            b_q       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            is_div_q  <= is_div_d;
            a_neg_q   <= a_neg_d;
            res_neg_q <= res_neg_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign dbz_o  = dbz_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered EX-stage ALU with start/busy/done handshake. Defining
// ALU_MULDIV_EN adds the iterative MULT/MULTU/DIV/DIVU engine and HI/LO registers.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]      srcA,
    input  logic [WIDTH-1:0]      srcB,
    output logic [WIDTH-1:0]      alu_result,
    output logic                  zero,
    output logic [WIDTH-1:0]      hi,
    output logic [WIDTH-1:0]      lo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_by_zero
);

    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] alu_result_q, alu_result_d;
    logic             zero_q, zero_d;
    logic             sc_done_q, sc_done_d;
    logic             accept, sc_accept;

    always_comb begin
        alu_out = '0;
        case (alu_op_e'(alu_control))
            ALU_AND: alu_out = srcA & srcB;
            ALU_OR:  alu_out = srcA | srcB;
            ALU_ADD: alu_out = srcA + srcB;
            ALU_SUB: alu_out = srcA - srcB;
            ALU_SLT: alu_out = {{(WIDTH-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
            ALU_NOR: alu_out = ~(srcA | srcB);
            default: alu_out = '0;
        endcase
    end

    // A start is only taken while idle; anything issued during a mul/div is dropped.
    assign accept = start && !busy;

`ifdef ALU_MULDIV_EN
    logic             md_start, md_busy, md_done, md_dbz;
    logic [WIDTH-1:0] md_hi, md_lo;

    assign md_start  = accept && is_muldiv(alu_control);
    assign sc_accept = accept && !is_muldiv(alu_control);

    muldiv_seq #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk        (clk),
        .reset      (reset),
        .start_i    (md_start),
        .is_div_i   (alu_control[1]),
        .is_signed_i(!alu_control[0]),
        .a_i        (srcA),
        .b_i        (srcB),
        .busy_o     (md_busy),
        .done_o     (md_done),
        .dbz_o      (md_dbz),
        .hi_o       (md_hi),
        .lo_o       (md_lo)
    );

    assign busy        = md_busy;
    assign hi          = md_hi;
    assign lo          = md_lo;
    assign div_by_zero = md_dbz;
    assign done        = sc_done_q | md_done;
`else
    assign sc_accept   = accept;
    assign busy        = 1'b0;
    assign hi          = '0;
    assign lo          = '0;
    assign div_by_zero = 1'b0;
    assign done        = sc_done_q;
`endif

    always_comb begin
        alu_result_d = sc_accept ? alu_out : alu_result_q;
        zero_d       = sc_accept ? (alu_out == '0) : zero_q;
        sc_done_d    = sc_accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_result_q <= '0;
            zero_q       <= 1'b0;
            sc_done_q    <= 1'b0;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            sc_done_q    <= sc_done_d;
        end
    end

    assign alu_result = alu_result_q;
    assign zero       = zero_q;

endmodule
